// File: rtl/ps2_host_tx_if.sv
// Command-byte transmit handshake plus the PS/2 pad-facing clock/data signals.
interface ps2_host_tx_if;
    logic [7:0] tx_byte;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;

    modport master (
        output tx_byte, tx_start, ps2_clk_in, ps2_data_in,
        input  tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe
    );

    modport slave (
        input  tx_byte, tx_start, ps2_clk_in, ps2_data_in,
        output tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, then
// shifts one command byte out on device-generated clock edges and checks the ACK.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 3000,
    parameter int unsigned RTS_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 375000,
    parameter int unsigned TIMER_WIDTH    = 19
) (
    input  logic         px_clk,
    input  logic         clr,
    ps2_host_tx_if.slave bus
);

    localparam int unsigned BITCNT_WIDTH = 4;

    localparam logic [TIMER_WIDTH-1:0]  INHIBIT_LAST = TIMER_WIDTH'(INHIBIT_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0]  RTS_LAST     = TIMER_WIDTH'(RTS_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0]  TIMEOUT_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0]  TIMER_MAX    = '1;
    localparam logic [BITCNT_WIDTH-1:0] LAST_DATA    = BITCNT_WIDTH'(8);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INHIBIT   = 3'd1;
    localparam logic [2:0] ST_RTS       = 3'd2;
    localparam logic [2:0] ST_SHIFT     = 3'd3;
    localparam logic [2:0] ST_ACK       = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

    logic [2:0]              state,   state_nxt;
    logic [TIMER_WIDTH-1:0]  timer,   timer_nxt;
    logic [TIMER_WIDTH-1:0]  timer_inc;
    logic [BITCNT_WIDTH-1:0] bitcnt,  bitcnt_nxt;
    logic [7:0]              shreg,   shreg_nxt;
    logic                    parity,  parity_nxt;
    logic                    busy_r,  busy_nxt;
    logic                    done_r,  done_nxt;
    logic                    error_r, error_nxt;
    logic                    clk_oe_r,  clk_oe_nxt;
    logic                    data_oe_r, data_oe_nxt;

    logic clk_meta, clk_sync, clk_prev;
    logic data_meta, data_sync;
    logic clk_fall;
    logic watched;

    // Two-flop synchronizers on the raw pads; idle bus level is high.
    always_ff @(posedge px_clk) begin
        if (clr) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= bus.ps2_clk_in;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= bus.ps2_data_in;
            data_sync <= data_meta;
        end
    end

    assign clk_fall  = clk_prev & ~clk_sync;
    assign timer_inc = (timer == TIMER_MAX) ? timer : timer + TIMER_WIDTH'(1);
    assign watched   = (state == ST_SHIFT) || (state == ST_ACK) || (state == ST_WAIT_IDLE);

    // State and registered-output update.
    always_ff @(posedge px_clk) begin
        if (clr) begin
            state     <= ST_IDLE;
            timer     <= '0;
            bitcnt    <= '0;
            shreg     <= '0;
            parity    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
            clk_oe_r  <= 1'b0;
            data_oe_r <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            bitcnt    <= bitcnt_nxt;
            shreg     <= shreg_nxt;
            parity    <= parity_nxt;
            busy_r    <= busy_nxt;
            done_r    <= done_nxt;
            error_r   <= error_nxt;
            clk_oe_r  <= clk_oe_nxt;
            data_oe_r <= data_oe_nxt;
        end
    end

    // Next-state logic; line drive is decided from the state being entered.
    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        bitcnt_nxt  = bitcnt;
        shreg_nxt   = shreg;
        parity_nxt  = parity;
        done_nxt    = 1'b0;
        error_nxt   = 1'b0;
        clk_oe_nxt  = 1'b0;
        data_oe_nxt = data_oe_r;

        case (state)
            ST_IDLE: begin
                data_oe_nxt = 1'b0;
                if (bus.tx_start) begin
                    shreg_nxt  = bus.tx_byte;
                    parity_nxt = ~^bus.tx_byte;
                    timer_nxt  = '0;
                    clk_oe_nxt = 1'b1;
                    state_nxt  = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                clk_oe_nxt  = 1'b1;
                data_oe_nxt = 1'b0;
                timer_nxt   = timer_inc;
                if (timer == INHIBIT_LAST) begin
                    timer_nxt   = '0;
                    data_oe_nxt = 1'b1;
                    state_nxt   = ST_RTS;
                end
            end
            ST_RTS: begin
                clk_oe_nxt  = 1'b1;
                data_oe_nxt = 1'b1;
                timer_nxt   = timer_inc;
                if (timer == RTS_LAST) begin
                    timer_nxt  = '0;
                    bitcnt_nxt = '0;
                    clk_oe_nxt = 1'b0;
                    state_nxt  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                timer_nxt = timer_inc;
                if (clk_fall) begin
                    timer_nxt  = '0;
                    bitcnt_nxt = bitcnt + BITCNT_WIDTH'(1);
                    if (bitcnt < LAST_DATA) begin
                        data_oe_nxt = ~shreg[0];
                        shreg_nxt   = {1'b0, shreg[7:1]};
                    end else if (bitcnt == LAST_DATA) begin
                        data_oe_nxt = ~parity;
                    end else begin
                        data_oe_nxt = 1'b0;
                        state_nxt   = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                timer_nxt = timer_inc;
                if (clk_fall) begin
                    timer_nxt = '0;
                    if (data_sync) begin
                        error_nxt = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                timer_nxt = clk_fall ? '0 : timer_inc;
                if (clk_sync && data_sync) begin
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                data_oe_nxt = 1'b0;
                state_nxt   = ST_IDLE;
            end
        endcase

        // Device stalled too long between clock edges: abandon the frame.
        if (watched && !clk_fall && (timer == TIMEOUT_LAST) && (state_nxt != ST_IDLE)) begin
            error_nxt = 1'b1;
            state_nxt = ST_IDLE;
        end

        if (state_nxt == ST_IDLE) begin
            clk_oe_nxt  = 1'b0;
            data_oe_nxt = 1'b0;
        end
        busy_nxt = (state_nxt != ST_IDLE);
    end

    assign bus.tx_busy     = busy_r;
    assign bus.tx_done     = done_r;
    assign bus.tx_error    = error_r;
    assign bus.ps2_clk_oe  = clk_oe_r;
    assign bus.ps2_data_oe = data_oe_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int unsigned INHIBIT = 3000;
    localparam int unsigned RTS     = 16;
    localparam int unsigned TIMEOUT = 4000;
    localparam int          HALF    = 50;

    logic px_clk = 1'b0;
    logic clr;
    logic dev_clk;
    logic dev_data;
    int   checks = 0;
    int   errors = 0;
    int   done_seen = 0;
    int   err_seen  = 0;
    logic [9:0] bits;

    ps2_host_tx_if bus ();

    ps2_host_tx #(
        .INHIBIT_CYCLES (INHIBIT),
        .RTS_CYCLES     (RTS),
        .TIMEOUT_CYCLES (TIMEOUT),
        .TIMER_WIDTH    (19)
    ) dut (
        .px_clk (px_clk),
        .clr    (clr),
        .bus    (bus)
    );

    always #5 px_clk = ~px_clk;

    // Open-drain wiring: either side may pull a line low.
    assign bus.ps2_clk_in  = dev_clk  & ~bus.ps2_clk_oe;
    assign bus.ps2_data_in = dev_data & ~bus.ps2_data_oe;

    always @(negedge px_clk) begin
        if (bus.tx_done === 1'b1)  done_seen++;
        if (bus.tx_error === 1'b1) err_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {busy, done, error, clk_oe, data_oe}
    function automatic logic [4:0] status();
        return {bus.tx_busy, bus.tx_done, bus.tx_error, bus.ps2_clk_oe, bus.ps2_data_oe};
    endfunction

    task automatic tick();
        @(posedge px_clk);
        #1;
    endtask

    task automatic start_tx(input logic [7:0] b);
        @(negedge px_clk);
        bus.tx_byte  = b;
        bus.tx_start = 1'b1;
        tick();
        bus.tx_start = 1'b0;
    endtask

    task automatic wait_shift(input string tag);
        int n = 0;
        while (bus.ps2_clk_oe !== 1'b0 && n < int'(INHIBIT + RTS + 20)) begin
            tick();
            n++;
        end
        chk({tag, "_shift_entry"}, 32'(status()), 32'b10001);
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (bus.tx_done !== 1'b1 && bus.tx_error !== 1'b1 && n < 2000);
        chk({tag, "_end_seen"}, 32'(bus.tx_done | bus.tx_error), 32'd1);
    endtask

    // Device clocks n_edges falling edges and samples data mid-high; ACK pulls data on edge 11.
    task automatic dev_frame(input int n_edges, input bit ack, output logic [9:0] got);
        got = '0;
        repeat (HALF) @(negedge px_clk);
        for (int k = 1; k <= n_edges; k++) begin
            if (k == 11 && ack) begin
                dev_data = 1'b0;
                repeat (HALF / 2) @(negedge px_clk);
            end
            dev_clk = 1'b0;
            repeat (HALF) @(negedge px_clk);
            dev_clk = 1'b1;
            repeat (HALF / 2) @(negedge px_clk);
            if (k <= 10) got[k-1] = bus.ps2_data_in;
            repeat (HALF / 2) @(negedge px_clk);
        end
        dev_data = 1'b1;
    endtask

    // Frame and done checks for a transfer already in SHIFT.
    task automatic finish_ok(input string tag, input logic [9:0] exp_bits);
        int d0;
        int e0;
        logic [9:0] got;
        d0 = done_seen;
        e0 = err_seen;
        dev_frame(11, 1'b1, got);
        chk({tag, "_frame"}, 32'(got), 32'(exp_bits));
        wait_end(tag);
        chk({tag, "_done_cycle"}, 32'(status()), 32'b01000);
        tick();
        chk({tag, "_after"}, 32'(status()), 32'b00000);
        chk({tag, "_done_count"}, 32'(done_seen - d0), 32'd1);
        chk({tag, "_err_count"}, 32'(err_seen - e0), 32'd0);
    endtask

    initial begin
        int n;
        int d0;
        int e0;

        clr          = 1'b1;
        dev_clk      = 1'b1;
        dev_data     = 1'b1;
        bus.tx_byte  = 8'h00;
        bus.tx_start = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", 32'(status()), 32'b00000);
        @(negedge px_clk);
        clr = 1'b0;
        repeat (3) tick();
        chk("idle_outputs", 32'(status()), 32'b00000);

        // 0xED with request timing relative to the accepting edge.
        start_tx(8'hED);
        chk("req_t1", 32'(status()), 32'b10010);
        repeat (INHIBIT - 1) tick();
        chk("req_t3000", 32'(status()), 32'b10010);
        tick();
        chk("req_t3001", 32'(status()), 32'b10011);
        repeat (RTS - 1) tick();
        chk("req_t3016", 32'(status()), 32'b10011);
        tick();
        chk("req_t3017", 32'(status()), 32'b10001);
        finish_ok("ed", 10'b11_11101101);

        start_tx(8'hFF);
        wait_shift("ff");
        finish_ok("ff", 10'b11_11111111);

        start_tx(8'h01);
        wait_shift("x01");
        finish_ok("x01", 10'b10_00000001);

        // Device leaves data released at the ACK edge.
        d0 = done_seen;
        e0 = err_seen;
        start_tx(8'hF4);
        wait_shift("nack");
        dev_frame(10, 1'b0, bits);
        chk("nack_frame", 32'(bits), 32'(10'b10_11110100));
        dev_clk = 1'b0;
        wait_end("nack");
        chk("nack_err_cycle", 32'(status()), 32'b00100);
        tick();
        chk("nack_after", 32'(status()), 32'b00000);
        @(negedge px_clk);
        dev_clk = 1'b1;
        repeat (4) tick();
        chk("nack_done_count", 32'(done_seen - d0), 32'd0);
        chk("nack_err_count", 32'(err_seen - e0), 32'd1);

        // Device never clocks: timeout, with a tx_start issued mid-wait.
        start_tx(8'hAA);
        wait_shift("tmo");
        n = 0;
        while (bus.tx_error !== 1'b1 && n < int'(TIMEOUT + 50)) begin
            tick();
            n++;
            if (n == 100) begin
                bus.tx_byte  = 8'h55;
                bus.tx_start = 1'b1;
            end else begin
                bus.tx_start = 1'b0;
            end
        end
        chk("tmo_latency", 32'(n), 32'(TIMEOUT));
        chk("tmo_err_cycle", 32'(status()), 32'b00100);
        tick();
        chk("tmo_after", 32'(status()), 32'b00000);
        repeat (10) tick();
        chk("tmo_no_queue", 32'(status()), 32'b00000);

        // Reset after edge 5, then a clean resend.
        d0 = done_seen;
        e0 = err_seen;
        start_tx(8'hED);
        wait_shift("clr");
        dev_frame(5, 1'b0, bits);
        chk("clr_partial", 32'(bits), 32'(10'b00000_01101));
        chk("clr_before", 32'(status()), 32'b10001);
        @(negedge px_clk);
        clr = 1'b1;
        tick();
        chk("clr_released", 32'(status()), 32'b00000);
        @(negedge px_clk);
        clr = 1'b0;
        repeat (4) tick();
        chk("clr_no_pulse", 32'(done_seen - d0 + err_seen - e0), 32'd0);
        start_tx(8'hED);
        wait_shift("ed2");
        finish_ok("ed2", 10'b11_11101101);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
